// File: rtl/inst_mem_uart_reader_pkg.sv
// Shared types and constants for the instruction-memory UART readback engine.
// Holds the FSM encoding, the ACK timeout and the bytes-per-word helper.
package inst_mem_uart_reader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RD      = 3'd1;
    localparam state_t ST_RD_WAIT = 3'd2;
    localparam state_t ST_SEND    = 3'd3;
    localparam state_t ST_ACK     = 3'd4;
    localparam state_t ST_DRAIN   = 3'd5;
    localparam state_t ST_FIN     = 3'd6;

    localparam int ACK_TIMEOUT = 16;
    localparam int TO_W        = $clog2(ACK_TIMEOUT);

    function automatic int bytes_per_word(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/inst_mem_uart_reader_if.sv
// Bundle of the start/status, memory-read and transmitter signals of the
// readback engine; master is the engine, slave is the surrounding system.
interface inst_mem_uart_reader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);

    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [7:0]            tx_data;
    logic                  tx_wr_en;
    logic                  tx_busy;

    modport master (
        input  start,
        input  mem_rdata,
        input  tx_busy,
        output busy,
        output done,
        output mem_rd_en,
        output mem_addr,
        output tx_data,
        output tx_wr_en
    );

    modport slave (
        output start,
        output mem_rdata,
        output tx_busy,
        input  busy,
        input  done,
        input  mem_rd_en,
        input  mem_addr,
        input  tx_data,
        input  tx_wr_en
    );

endinterface

// File: rtl/inst_mem_uart_reader_word_serializer.sv
// Word register plus byte index: load a word, then step through its bytes
// little-endian; last flags the final byte of the word.
module inst_mem_uart_reader_word_serializer
    import inst_mem_uart_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  next,
    input  logic [DATA_WIDTH-1:0] word_in,
    output logic [7:0]            byte_out,
    output logic                  last
);

    localparam int BPW = bytes_per_word(DATA_WIDTH);
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_WIDTH-1:0] word_q;
    logic [IW-1:0]         idx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            word_q <= word_in;
            idx_q  <= '0;
        end else if (next) begin
            idx_q  <= idx_q + 1'b1;
        end
    end

    assign byte_out = word_q[{idx_q, 3'b000} +: 8];
    assign last     = (idx_q == IW'(BPW - 1));

endmodule

// File: rtl/inst_mem_uart_reader.sv
// Readback engine: on start, reads NUM_WORDS words from address 0 and
// streams them byte-by-byte to the UART transmitter.
module inst_mem_uart_reader
    import inst_mem_uart_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 64
) (
    input logic                   clk,
    input logic                   rst,
    inst_mem_uart_reader_if.master bus
);

    localparam int                CW        = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]     LAST_WORD = CW'(NUM_WORDS - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

    state_t            state_q;
    logic [CW-1:0]     wcnt_q;
    logic [TO_W-1:0]   tcnt_q;
    logic [7:0]        txd_q;

    logic [7:0]        ser_byte;
    logic              ser_last;
    logic              ser_load;
    logic              ser_next;
    logic              tx_fire;
    logic              drained;

    assign tx_fire  = (state_q == ST_SEND) && !bus.tx_busy;
    assign drained  = (state_q == ST_DRAIN) && !bus.tx_busy;
    assign ser_load = (state_q == ST_RD_WAIT);
    assign ser_next = drained && !ser_last;

    inst_mem_uart_reader_word_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .next     (ser_next),
        .word_in  (bus.mem_rdata),
        .byte_out (ser_byte),
        .last     (ser_last)
    );

    // ACK leaves on busy or after ACK_TIMEOUT cycles, in case the
    // transmitter finished before busy could be seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            txd_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_RD;
                        wcnt_q  <= '0;
                    end
                end
                ST_RD: begin
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_fire) begin
                        state_q <= ST_ACK;
                        tcnt_q  <= '0;
                        txd_q   <= ser_byte;
                    end
                end
                ST_ACK: begin
                    if (bus.tx_busy || tcnt_q == TO_LAST) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        tcnt_q  <= tcnt_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        if (!ser_last) begin
                            state_q <= ST_SEND;
                        end else if (wcnt_q != LAST_WORD) begin
                            state_q <= ST_RD;
                            wcnt_q  <= wcnt_q + 1'b1;
                        end else begin
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd_en = (state_q == ST_RD);
    assign bus.mem_addr  = wcnt_q[ADDR_WIDTH-1:0];
    assign bus.tx_wr_en  = tx_fire;
    assign bus.tx_data   = tx_fire ? ser_byte : txd_q;
    assign bus.done      = (state_q == ST_FIN);
    assign bus.busy      = (state_q != ST_IDLE) && (state_q != ST_FIN);

endmodule

// File: doc/inst_mem_uart_reader.md
Name: inst_mem_uart_reader

Overview:
- Readback engine for the instruction-memory UART loader.
- On a start pulse, it reads NUM_WORDS 32-bit words from instruction memory, starting at address 0.
- It splits each word into bytes and hands them one at a time to the UART transmitter (data_in / wr_en / Tx_busy handshake).
- Lets the host verify a loaded program; sits beside the instruction-memory wrapper in the top-level.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width.
- DATA_WIDTH, 32, memory word width; must be a multiple of 8.
- NUM_WORDS, 64, words dumped per start; 1 <= NUM_WORDS <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a dump; ignored unless idle.
- mem_rd_en  out  1  memory read strobe, one cycle per word.
- mem_addr  out  ADDR_WIDTH  word address, valid while mem_rd_en is high.
- mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- tx_data  out  8  byte to transmitter; held stable from tx_wr_en until the byte completes.
- tx_wr_en  out  1  single-cycle write pulse to transmitter.
- tx_busy  in  1  transmitter busy flag.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse after the last byte completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE.
  - All outputs 0; word counter, byte index and data register cleared.
- States: IDLE, RD, RD_WAIT, SEND, ACK, DRAIN, FIN.
- IDLE:
  - start=1 -> RD, word counter=0.
  - Otherwise stay in IDLE.
- RD:
  - mem_rd_en=1, mem_addr=word counter, for one cycle.
  - -> RD_WAIT.
- RD_WAIT:
  - Capture mem_rdata into the word register.
  - byte index=0 -> SEND.
- SEND:
  - If tx_busy=1, wait here.
  - Else drive tx_data = word[8*idx+7 : 8*idx] (little-endian, byte 0 first), pulse tx_wr_en=1 for one cycle -> ACK.
- ACK:
  - Wait for tx_busy=1, then -> DRAIN.
  - A 16-cycle timeout counter also -> DRAIN, covering a transmitter that finishes before busy is sampled.
- DRAIN: wait for tx_busy=0, then:
  - idx < DATA_WIDTH/8-1: idx++ -> SEND.
  - Last byte of the word, word counter < NUM_WORDS-1: counter++ -> RD.
  - Last byte of the last word -> FIN.
- FIN:
  - done=1 for one cycle -> IDLE; busy falls in the same cycle.
- Timing:
  - Latency from start to first tx_wr_en is 3 cycles (IDLE->RD->RD_WAIT->SEND), given tx_busy=0.
  - Exactly NUM_WORDS*DATA_WIDTH/8 tx_wr_en pulses per dump; never two pulses without an intervening busy/drain.
- Counters:
  - The word counter is ADDR_WIDTH+1 bits, so NUM_WORDS = 2**ADDR_WIDTH does not wrap.
  - mem_addr is its low ADDR_WIDTH bits.
- Boundary and conflict cases:
  - start while busy: ignored, with no restart or queueing.
  - start together with FIN: ignored; a new start is required after IDLE.
  - tx_busy already high when entering SEND: waits in SEND; no byte is dropped.
  - Reset mid-dump: immediate return to IDLE, tx_wr_en and mem_rd_en forced 0, no done pulse. A byte already handed to the transmitter completes on its own.
- tx_data holds its last value between pulses. It resets to 0x00.

Decomposition:
- Shared package (uart_pkg):
  - FSM state encoding typedef.
  - BYTES_PER_WORD = DATA_WIDTH/8.
  - ACK_TIMEOUT = 16.
- Natural sub-module: word_serializer.
  - Holds the word register, byte index and byte mux.
  - Load / next / last handshake.
  - The top FSM owns the memory and transmitter handshakes.

Test Plan:
- Memory preloaded 0x00000013 @0, 0xDEADBEEF @1; NUM_WORDS=2; transmitter model asserts busy 1 cycle after wr_en for 10 cycles; pulse start. Required:
  - Bytes 13 00 00 00 EF BE AD DE in order.
  - 8 wr_en pulses, 2 mem_rd_en pulses at addresses 0, 1.
  - One done pulse; busy low afterwards.
- Hold tx_busy=1 for 50 cycles at start -> first tx_wr_en only after tx_busy falls; no pulse while busy=1.
- Pulse start again mid-dump (after byte 3) -> no extra reads, total still 8 bytes, a single done pulse.
- Assert rst during DRAIN of byte 5 -> outputs 0 within the reset cycle, no done. A fresh start restarts from address 0 with byte 0x13.
- Transmitter model that never raises busy (instant) -> ACK timeout advances after 16 cycles; all 8 bytes emitted; done fires.
- NUM_WORDS=256, ADDR_WIDTH=8 -> addresses 0..255 read once each, no wrap to 0, 1024 bytes sent, then done.
